uart_tx: RTL and testbench

UART transmitter serialising 8-bit bytes onto `uart_txd_o` as start bit, 8 data bits LSB first, optional parity bit, then 1 or 2 stop bits. It pairs with the UART receiver on the same `uart_clk_en_i` oversample tick and parity settings. A one-entry holding register lets the host hand over the next byte while the current frame shifts, so consecutive frames leave the line with no idle gap.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_clk_div.sv | 30 +++
 rtl/uart_parity.sv | 13 +
 rtl/uart_tx.sv | 150 +++++++++++++++
 tb/tb_uart_tx.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding common to transmitter and receiver,
// plus the parity-type names used as string parameters.
package uart_pkg;

  typedef enum logic [2:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_PARITY,
    UART_STOP
  } uart_state_e;

  localparam string ParityNone = "none";
  localparam string ParityEven = "even";
  localparam string ParityOdd  = "odd";

endpackage

// File: rtl/uart_clk_div.sv
// Bit timer: counts oversample ticks 0..DivMaxVal-1 and pulses wrap_o on the
// tick that ends a bit period. clear_i holds the count at zero.
module uart_clk_div #(
  parameter int DivMaxVal = 16
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic clear_i,
  input  logic clk_en_i,
  output logic wrap_o
);

  localparam int              CntW   = (DivMaxVal > 1) ? $clog2(DivMaxVal) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DivMaxVal - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (clk_en_i) begin
      cnt_q <= (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    end
  end

  assign wrap_o = clk_en_i && !clear_i && (cnt_q == CntMax);

endmodule

// File: rtl/uart_parity.sv
// Parity generator for one data byte; odd parity inverts the XOR reduction.
module uart_parity
  import uart_pkg::*;
#(
  parameter string ParityType = "even"
) (
  input  logic [7:0] data_i,
  output logic       parity_o
);

  assign parity_o = (^data_i) ^ (ParityType == ParityOdd);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2
// stop bits, with a one-byte holding register for gap-free back-to-back frames.
module uart_tx
  import uart_pkg::*;
#(
  parameter int    ClkDivVal = 16,
  parameter string ParityBit = "none",
  parameter int    StopBits  = 1
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       uart_clk_en_i,
  input  logic [7:0] data_i,
  input  logic       data_valid_i,
  output logic       tx_ready_o,
  output logic       tx_busy_o,
  output logic       tx_done_o,
  output logic       uart_txd_o
);

  localparam bit   ParityEn = (ParityBit != ParityNone);
  localparam logic StopLast = 1'(StopBits - 1);

  uart_state_e state_q;
  logic [7:0]  shift_q;
  logic [7:0]  hold_q;
  logic        hold_full_q;
  logic [2:0]  bit_idx_q;
  logic        stop_idx_q;
  logic        txd_q;
  logic        done_q;

  logic        bit_done;
  logic        parity_bit;
  logic        accept;
  logic [2:0]  bit_idx_nxt;

  assign accept      = data_valid_i & ~hold_full_q;
  assign bit_idx_nxt = bit_idx_q + 3'd1;

  uart_clk_div #(
    .DivMaxVal(ClkDivVal)
  ) u_bit_timer (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .clear_i  (state_q == UART_IDLE),
    .clk_en_i (uart_clk_en_i),
    .wrap_o   (bit_done)
  );

  // The shift register is never shifted (bits are indexed), so it still holds
  // the loaded byte when the parity bit goes out.
  uart_parity #(
    .ParityType(ParityBit)
  ) u_parity (
    .data_i  (shift_q),
    .parity_o(parity_bit)
  );

  // Accept and load are mutually exclusive: accept needs an empty holding
  // register, load needs a full one. The line register changes together with
  // the state so it always reflects the current bit.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= UART_IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      txd_q       <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        hold_q      <= data_i;
        hold_full_q <= 1'b1;
      end
      unique case (state_q)
        UART_IDLE: begin
          if (hold_full_q) begin
            shift_q     <= hold_q;
            hold_full_q <= 1'b0;
            state_q     <= UART_START;
            txd_q       <= 1'b0;
          end
        end
        UART_START: begin
          if (bit_done) begin
            state_q   <= UART_DATA;
            bit_idx_q <= '0;
            txd_q     <= shift_q[0];
          end
        end
        UART_DATA: begin
          if (bit_done) begin
            bit_idx_q <= bit_idx_nxt;
            if (bit_idx_q == 3'd7) begin
              if (ParityEn) begin
                state_q <= UART_PARITY;
                txd_q   <= parity_bit;
              end else begin
                state_q    <= UART_STOP;
                stop_idx_q <= 1'b0;
                txd_q      <= 1'b1;
              end
            end else begin
              txd_q <= shift_q[bit_idx_nxt];
            end
          end
        end
        UART_PARITY: begin
          if (bit_done) begin
            state_q    <= UART_STOP;
            stop_idx_q <= 1'b0;
            txd_q      <= 1'b1;
          end
        end
        UART_STOP: begin
          if (bit_done) begin
            if (stop_idx_q == StopLast) begin
              done_q <= 1'b1;
              if (hold_full_q) begin
                shift_q     <= hold_q;
                hold_full_q <= 1'b0;
                state_q     <= UART_START;
                txd_q       <= 1'b0;
              end else begin
                state_q <= UART_IDLE;
                txd_q   <= 1'b1;
              end
            end else begin
              stop_idx_q <= stop_idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= UART_IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

  assign uart_txd_o = txd_q;
  assign tx_done_o  = done_q;
  assign tx_ready_o = ~hold_full_q;
  assign tx_busy_o  = (state_q != UART_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances cover no/even/odd parity and a
// two-stop-bit variant driven by a tick every 4th clock.
module tb_uart_tx;

  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic [3:0] valid;
  logic [7:0] data [4];
  wire  [3:0] ready;
  wire  [3:0] busy;
  wire  [3:0] done;
  wire  [3:0] txd;
  logic [1:0] div4 = 2'd0;
  wire        tick4;

  int checks   = 0;
  int failures = 0;

  logic [11:0] bits;
  int          len;
  int          rdy;
  int          low_seen;
  int          wait_k;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) div4 <= div4 + 2'd1;
  assign tick4 = (div4 == 2'd0);

  uart_tx #(.ClkDivVal(16), .ParityBit("none"), .StopBits(1)) dut_none (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .uart_clk_en_i(1'b1),
    .data_i(data[0]), .data_valid_i(valid[0]), .tx_ready_o(ready[0]),
    .tx_busy_o(busy[0]), .tx_done_o(done[0]), .uart_txd_o(txd[0]));

  uart_tx #(.ClkDivVal(16), .ParityBit("even"), .StopBits(1)) dut_even (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .uart_clk_en_i(1'b1),
    .data_i(data[1]), .data_valid_i(valid[1]), .tx_ready_o(ready[1]),
    .tx_busy_o(busy[1]), .tx_done_o(done[1]), .uart_txd_o(txd[1]));

  uart_tx #(.ClkDivVal(16), .ParityBit("odd"), .StopBits(1)) dut_odd (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .uart_clk_en_i(1'b1),
    .data_i(data[2]), .data_valid_i(valid[2]), .tx_ready_o(ready[2]),
    .tx_busy_o(busy[2]), .tx_done_o(done[2]), .uart_txd_o(txd[2]));

  uart_tx #(.ClkDivVal(16), .ParityBit("none"), .StopBits(2)) dut_stop2 (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .uart_clk_en_i(tick4),
    .data_i(data[3]), .data_valid_i(valid[3]), .tx_ready_o(ready[3]),
    .tx_busy_o(busy[3]), .tx_done_o(done[3]), .uart_txd_o(txd[3]));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Offers one byte once ready is high; returns on the negedge after the accept.
  task automatic applyStimulus(input int idx, input logic [7:0] b);
    int k = 0;
    while (ready[idx] !== 1'b1 && k < 2000) begin
      @(negedge clk_i);
      k++;
    end
    checkOutput("ready_wait", 32'(ready[idx]), 32'd1);
    data[idx]  = b;
    valid[idx] = 1'b1;
    @(negedge clk_i);
    valid[idx] = 1'b0;
  endtask

  // Accepts first, then offers second so it lands in the holding register.
  // Returns one clock into the first frame with valid still asserted.
  task automatic startPair(input int idx, input logic [7:0] first, input logic [7:0] second);
    int k = 0;
    while (ready[idx] !== 1'b1 && k < 2000) begin
      @(negedge clk_i);
      k++;
    end
    checkOutput("pair_ready_wait", 32'(ready[idx]), 32'd1);
    data[idx]  = first;
    valid[idx] = 1'b1;
    @(negedge clk_i);
    data[idx] = second;
    @(negedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic waitIdle(input int idx);
    int k = 0;
    while ((busy[idx] !== 1'b0 || ready[idx] !== 1'b1) && k < 4000) begin
      @(negedge clk_i);
      k++;
    end
    checkOutput("idle_seen", 32'({busy[idx], ready[idx]}), 32'h1);
  endtask

  task automatic waitStart(input int idx);
    int k = 0;
    while (txd[idx] !== 1'b0 && k < 2000) begin
      @(negedge clk_i);
      k++;
    end
    checkOutput("start_seen", 32'(txd[idx]), 32'd0);
  endtask

  // Samples each bit mid-period counting clocks from the start-bit edge;
  // len is the clock count at which tx_done is seen (-1 on timeout).
  task automatic runFrame(input int idx, input int nbits, input int bitClks, input int startN,
                          output logic [11:0] fbits, output int flen, output int rdyHigh);
    int n = startN;
    fbits   = 'x;
    flen    = -1;
    rdyHigh = 0;
    while (n < 20 * bitClks) begin
      if (n > 0 && done[idx] === 1'b1) begin
        flen = n;
        break;
      end
      if (ready[idx] === 1'b1) rdyHigh++;
      if ((n % bitClks) == bitClks / 2 && (n / bitClks) < nbits) fbits[n / bitClks] = txd[idx];
      n++;
      @(negedge clk_i);
    end
  endtask

  task automatic measureRun(input int idx, input logic level, output int rlen);
    rlen = 0;
    while (txd[idx] === level && rlen < 2000) begin
      rlen++;
      @(negedge clk_i);
    end
  endtask

  initial begin
    reset_n_i = 1'b0;
    valid     = '0;
    data      = '{default: 8'h00};
    repeat (3) @(negedge clk_i);
    checkOutput("rst_txd", 32'(txd[0]), 32'd1);
    checkOutput("rst_ready", 32'(ready[0]), 32'd1);
    checkOutput("rst_busy", 32'(busy[0]), 32'd0);
    checkOutput("rst_done", 32'(done[0]), 32'd0);
    reset_n_i = 1'b1;
    @(negedge clk_i);

    // Single 0xA5 frame, no parity
    applyStimulus(0, 8'hA5);
    checkOutput("t1_ready_low", 32'(ready[0]), 32'd0);
    @(negedge clk_i);
    checkOutput("t1_start_txd", 32'(txd[0]), 32'd0);
    checkOutput("t1_busy", 32'(busy[0]), 32'd1);
    checkOutput("t1_ready_back", 32'(ready[0]), 32'd1);
    runFrame(0, 10, 16, 0, bits, len, rdy);
    checkOutput("t1_frame", 32'(bits[9:0]), 32'h34A);
    checkOutput("t1_len", 32'(len), 32'd160);
    checkOutput("t1_ready_free", 32'(rdy), 32'd160);
    checkOutput("t1_idle_line", 32'(txd[0]), 32'd1);
    @(negedge clk_i);
    checkOutput("t1_done_one_cycle", 32'(done[0]), 32'd0);

    // Parity variants
    applyStimulus(1, 8'hA5);
    @(negedge clk_i);
    runFrame(1, 11, 16, 0, bits, len, rdy);
    checkOutput("even_a5_frame", 32'(bits[10:0]), 32'h54A);
    checkOutput("even_a5_len", 32'(len), 32'd176);
    applyStimulus(2, 8'hA5);
    @(negedge clk_i);
    runFrame(2, 11, 16, 0, bits, len, rdy);
    checkOutput("odd_a5_frame", 32'(bits[10:0]), 32'h74A);
    checkOutput("odd_a5_len", 32'(len), 32'd176);
    applyStimulus(2, 8'h00);
    @(negedge clk_i);
    runFrame(2, 11, 16, 0, bits, len, rdy);
    checkOutput("odd_00_frame", 32'(bits[10:0]), 32'h600);
    checkOutput("odd_00_len", 32'(len), 32'd176);

    // Back-to-back 0x00 then 0xFF
    waitIdle(0);
    startPair(0, 8'h00, 8'hFF);
    checkOutput("b2b_ready_full", 32'(ready[0]), 32'd0);
    valid[0] = 1'b0;
    runFrame(0, 10, 16, 1, bits, len, rdy);
    checkOutput("b2b_frame1", 32'(bits[9:0]), 32'h200);
    checkOutput("b2b_len1", 32'(len), 32'd160);
    checkOutput("b2b_ready_held_low", 32'(rdy), 32'd0);
    checkOutput("b2b_zero_idle", 32'(txd[0]), 32'd0);
    checkOutput("b2b_busy", 32'(busy[0]), 32'd1);
    runFrame(0, 10, 16, 0, bits, len, rdy);
    checkOutput("b2b_frame2", 32'(bits[9:0]), 32'h3FE);
    checkOutput("b2b_len2", 32'(len), 32'd160);

    // Offers while full are ignored (0x33), 0x44 taken once ready rises
    waitIdle(0);
    startPair(0, 8'h11, 8'h22);
    data[0] = 8'h33;
    rdy = 0;
    for (int k = 0; k < 40; k++) begin
      if (ready[0] === 1'b1) rdy++;
      @(negedge clk_i);
    end
    data[0] = 8'h44;
    wait_k = 0;
    while (done[0] !== 1'b1 && wait_k < 400) begin
      if (ready[0] === 1'b1) rdy++;
      @(negedge clk_i);
      wait_k++;
    end
    checkOutput("hold_ready_low", 32'(rdy), 32'd0);
    checkOutput("hold_frame1_done", 32'(done[0]), 32'd1);
    checkOutput("hold_reload_ready", 32'(ready[0]), 32'd1);
    @(negedge clk_i);
    checkOutput("hold_44_accepted", 32'(ready[0]), 32'd0);
    valid[0] = 1'b0;
    runFrame(0, 10, 16, 1, bits, len, rdy);
    checkOutput("hold_frame_22", 32'(bits[9:0]), 32'h244);
    runFrame(0, 10, 16, 0, bits, len, rdy);
    checkOutput("hold_frame_44", 32'(bits[9:0]), 32'h288);
    checkOutput("hold_final_idle", 32'(busy[0]), 32'd0);

    // Tick every 4th clock, two stop bits, byte 0x0F
    applyStimulus(3, 8'h0F);
    waitStart(3);
    measureRun(3, 1'b0, len);
    checkOutput("div4_start_len", 32'(len >= 61 && len <= 64), 32'd1);
    measureRun(3, 1'b1, len);
    checkOutput("div4_ones_run", 32'(len), 32'd256);
    measureRun(3, 1'b0, len);
    checkOutput("div4_zeros_run", 32'(len), 32'd256);
    len      = 0;
    low_seen = 0;
    while (done[3] !== 1'b1 && len < 1000) begin
      if (txd[3] !== 1'b1) low_seen++;
      len++;
      @(negedge clk_i);
    end
    checkOutput("div4_stop_len", 32'(len), 32'd128);
    checkOutput("div4_stop_high", 32'(low_seen), 32'd0);

    // Reset mid-databits with a byte held
    waitIdle(0);
    startPair(0, 8'h00, 8'hFF);
    valid[0] = 1'b0;
    repeat (40) @(negedge clk_i);
    checkOutput("pre_reset_line", 32'(txd[0]), 32'd0);
    checkOutput("pre_reset_held", 32'(ready[0]), 32'd0);
    #2 reset_n_i = 1'b0;
    #1;
    checkOutput("async_rst_txd", 32'(txd[0]), 32'd1);
    checkOutput("async_rst_ready", 32'(ready[0]), 32'd1);
    checkOutput("async_rst_busy", 32'(busy[0]), 32'd0);
    checkOutput("async_rst_done", 32'(done[0]), 32'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    checkOutput("post_rst_idle", 32'({busy[0], txd[0]}), 32'h1);
    applyStimulus(0, 8'h5A);
    @(negedge clk_i);
    checkOutput("post_rst_start", 32'(txd[0]), 32'd0);
    runFrame(0, 10, 16, 0, bits, len, rdy);
    checkOutput("post_rst_frame", 32'(bits[9:0]), 32'h2B4);
    checkOutput("post_rst_len", 32'(len), 32'd160);
    repeat (20) @(negedge clk_i);
    checkOutput("held_discarded", 32'({busy[0], txd[0]}), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
